// File: rtl/breath_ctrl.sv
// Breathing-LED duty controller: manual key stepping or an auto up/hold/down/hold
// ramp, with duty changes applied only on PWM period boundaries.
module breath_ctrl #(
  parameter int CNT_NUM      = 8,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_STEPS   = 2,
  parameter int CNT_W        = $clog2(CNT_NUM),
  parameter int DUTY_W       = $clog2(CNT_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_mode,
  input  logic              key_up,
  input  logic              key_down,
  output logic              led,
  output logic [DUTY_W-1:0] duty,
  output logic [2:0]        state,
  output logic              period_end
);

  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_NUM - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(CNT_NUM);
  localparam logic [DUTY_W-1:0] DUTY_RST  = DUTY_W'(CNT_NUM / 2);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    MANUAL  = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_INC  = 2'd1,
    REQ_DEC  = 2'd2
  } req_t;

  logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  state_t            state_q, state_d;
  req_t              pend_q, pend_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        keys_q, keys_d;

  logic [2:0]        rise;
  logic              mode_rise, up_rise, down_rise;
  logic              step_tick;
  logic [DUTY_W-1:0] duty_inc, duty_dec;

  assign keys_d     = {key_mode, key_up, key_down};
  assign rise       = keys_d & ~keys_q;
  assign mode_rise  = rise[2];
  assign up_rise    = rise[1];
  assign down_rise  = rise[0];

  assign period_end = (pwm_cnt_q == CNT_LAST);
  assign step_tick  = period_end && (step_cnt_q == STEP_LAST);
  assign duty_inc   = (duty_q == DUTY_MAX) ? duty_q : duty_q + 1'b1;
  assign duty_dec   = (duty_q == '0) ? duty_q : duty_q - 1'b1;

  assign led   = ~(DUTY_W'(pwm_cnt_q) < duty_q);
  assign duty  = duty_q;
  assign state = state_q;

  always_comb begin
    pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + 1'b1;
    duty_d     = duty_q;
    state_d    = state_q;
    pend_d     = pend_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      MANUAL: begin
        if (mode_rise) begin
          state_d    = UP;
          pend_d     = REQ_NONE;
          step_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          if (period_end) begin
            if (pend_q == REQ_INC) duty_d = duty_inc;
            else if (pend_q == REQ_DEC) duty_d = duty_dec;
            pend_d = REQ_NONE;
          end
          // A rise landing on the boundary edge becomes the next period's request.
          if (up_rise && down_rise) pend_d = REQ_NONE;
          else if (up_rise)         pend_d = REQ_INC;
          else if (down_rise)       pend_d = REQ_DEC;
        end
      end

      UP, HOLD_HI, DOWN, HOLD_LO: begin
        if (mode_rise) begin
          state_d    = MANUAL;
          pend_d     = REQ_NONE;
          step_cnt_d = '0;
          hold_cnt_d = '0;
        end else if (period_end) begin
          step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
          if (step_tick) begin
            case (state_q)
              UP: begin
                duty_d = duty_inc;
                if (duty_inc == DUTY_MAX) state_d = HOLD_HI;
              end
              DOWN: begin
                duty_d = duty_dec;
                if (duty_dec == '0) state_d = HOLD_LO;
              end
              HOLD_HI, HOLD_LO: begin
                if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_d = '0;
                  state_d    = (state_q == HOLD_HI) ? DOWN : UP;
                end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q  <= '0;
      duty_q     <= DUTY_RST;
      state_q    <= MANUAL;
      pend_q     <= REQ_NONE;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      keys_q     <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      keys_q     <= keys_d;
    end
  end

endmodule

// File: tb/tb_breath_ctrl.sv
// Bench for breath_ctrl: integer-level model of the breathing behaviour checked every
// cycle, plus directed key sequences with literal expected duty/state/timing.
module tb_breath_ctrl;

  localparam int N     = 8;
  localparam int STEPS = 4;
  localparam int HOLDS = 2;

  localparam logic [2:0] K_MODE = 3'b100;
  localparam logic [2:0] K_UP   = 3'b010;
  localparam logic [2:0] K_DN   = 3'b001;
  localparam logic [2:0] K_UD   = 3'b011;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode, key_up, key_down;
  logic       led;
  logic [3:0] duty;
  logic [2:0] state;
  logic       period_end;

  int n_err    = 0;
  int n_checks = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  // model: phase 0=manual, 1=rising, 2=hold high, 3=falling, 4=hold low
  int m_cnt = 0, m_duty = N / 2, m_phase = 0, m_req = 0, m_periods = 0, m_holds = 0;
  int m_pm = 0, m_pu = 0, m_pd = 0;

  breath_ctrl #(.CNT_NUM(N), .STEP_PERIODS(STEPS), .HOLD_STEPS(HOLDS)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .led(led), .duty(duty), .state(state), .period_end(period_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_duty = N / 2; m_phase = 0; m_req = 0;
      m_periods = 0; m_holds = 0; m_pm = 0; m_pu = 0; m_pd = 0;
    end else begin
      int rm, ru, rd;
      bit boundary;
      rm = key_mode && !m_pm;
      ru = key_up && !m_pu;
      rd = key_down && !m_pd;
      boundary = (m_cnt == N - 1);
      if (rm) begin
        m_phase = (m_phase == 0) ? 1 : 0;
        m_req = 0; m_periods = 0; m_holds = 0;
      end else if (m_phase == 0) begin
        if (boundary) begin
          m_duty = m_duty + m_req;
          if (m_duty > N) m_duty = N;
          if (m_duty < 0) m_duty = 0;
          m_req = 0;
        end
        if (ru && rd) m_req = 0;
        else if (ru)  m_req = 1;
        else if (rd)  m_req = -1;
      end else if (boundary) begin
        m_periods++;
        if (m_periods == STEPS) begin
          m_periods = 0;
          if (m_phase == 1) begin
            if (m_duty < N) m_duty++;
            if (m_duty == N) m_phase = 2;
          end else if (m_phase == 3) begin
            if (m_duty > 0) m_duty--;
            if (m_duty == 0) m_phase = 4;
          end else begin
            m_holds++;
            if (m_holds == HOLDS) begin
              m_holds = 0;
              m_phase = (m_phase == 2) ? 3 : 1;
            end
          end
        end
      end
      m_cnt = (m_cnt + 1) % N;
      m_pm = key_mode; m_pu = key_up; m_pd = key_down;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("led", led, (m_cnt < m_duty) ? 0 : 1);
      chk("duty", duty, m_duty);
      chk("state", state, m_phase);
      chk("period_end", period_end, (m_cnt == N - 1) ? 1 : 0);
    end
  end

  // Raise the given keys so the DUT first samples them with pwm_cnt == phase.
  task automatic pulse(input logic [2:0] k, input int hold, input int phase);
    bit found = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (m_cnt == phase) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout("pulse_phase");
    {key_mode, key_up, key_down} = k;
    repeat (hold) @(negedge clk);
    {key_mode, key_up, key_down} = 3'b000;
  endtask

  task automatic wait_for(input bit on_duty, input int val, input int max, output int t);
    t = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if ((on_duty ? int'(duty) : int'(state)) == val) begin
        t = cyc;
        return;
      end
    end
    timeout(on_duty ? "wait_duty" : "wait_state");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int up_exp[6] = '{5, 6, 7, 8, 8, 8};
    int dn_exp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 0};
    int t1, t2, t3, t4, t7, tx;

    rst = 1'b0; key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_duty", duty, 4);
    chk("rst_state", state, 0);
    chk("rst_led", led, 0);
    chk("rst_period_end", period_end, 0);
    chk_en = 1'b1;
    repeat (16) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      pulse(K_UP, 1, 1);
      repeat (10) @(negedge clk);
      chk("man_up", duty, up_exp[i]);
    end
    for (int i = 0; i < 9; i++) begin
      pulse(K_DN, 1, 1);
      repeat (10) @(negedge clk);
      chk("man_down", duty, dn_exp[i]);
    end

    pulse(K_UP, 1, 1);
    repeat (10) @(negedge clk);
    chk("man_up_from0", duty, 1);
    pulse(K_UD, 1, 1);
    repeat (10) @(negedge clk);
    chk("man_both", duty, 1);
    pulse(K_UP, 1, 1);
    pulse(K_DN, 1, 4);
    repeat (10) @(negedge clk);
    chk("man_up_then_down", duty, 0);
    pulse(K_UP, 50, 1);
    repeat (10) @(negedge clk);
    chk("man_up_held", duty, 1);
    for (int i = 0; i < 3; i++) begin
      pulse(K_UP, 1, 2);
      repeat (10) @(negedge clk);
    end
    chk("man_back_to_4", duty, 4);

    pulse(K_MODE, 1, 1);
    chk("auto_enter", state, 1);
    pulse(K_UP, 1, 3);
    chk("auto_up_ignored", duty, 4);
    wait_for(1'b0, 2, 200, t1);
    chk("hold_hi_duty", duty, 8);
    wait_for(1'b0, 3, 100, t2);
    chk("hold_hi_len", t2 - t1, 64);
    wait_for(1'b0, 4, 300, t3);
    chk("hold_lo_duty", duty, 0);
    wait_for(1'b0, 1, 100, t4);
    chk("hold_lo_len", t4 - t3, 64);
    pulse(K_DN, 1, 3);
    wait_for(1'b0, 4, 700, t7);
    chk("breath_cycle", t7 - t3, 640);

    wait_for(1'b0, 1, 100, tx);
    wait_for(1'b0, 2, 300, tx);
    wait_for(1'b0, 3, 100, tx);
    wait_for(1'b1, 6, 100, tx);
    pulse(K_MODE, 1, 2);
    chk("exit_state", state, 0);
    chk("exit_duty", duty, 6);
    pulse(K_UP, 1, 2);
    repeat (10) @(negedge clk);
    chk("exit_then_up", duty, 7);

    pulse(K_MODE, 1, 1);
    wait_for(1'b0, 2, 200, tx);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_duty", duty, 4);
    chk("midrst_led", led, 0);
    chk("midrst_period_end", period_end, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
